// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising RAM arbiter: FSM states, owners,
// access sizes and the fixed RAM read latency.
package mem_ctrl_pkg;

  localparam int RAM_RD_LAT = 1;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  // Any size other than a byte or halfword is serviced as a full word.
  function automatic logic [2:0] normSize(input logic [2:0] n);
    case (n)
      SZ_B:    return SZ_B;
      SZ_H:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side (IF, MEM) and RAM-side signals of the memory controller.
// The controller takes the slave view; the pipeline/RAM environment takes master.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              load_or_not;
  logic              store_or_not;
  logic [2:0]        num_of_bytes;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       store_data;
  logic              mem_enable;
  logic [31:0]       load_data;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, load_or_not, store_or_not, num_of_bytes,
           mem_addr, store_data, ram_din,
    output if_done, if_data, mem_enable, load_data, ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, load_or_not, store_or_not, num_of_bytes,
           mem_addr, store_data, ram_din,
    input  if_done, if_data, mem_enable, load_data, ram_addr, ram_dout, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM onto one byte-wide RAM port, splitting each 1/2/4-byte
// request into little-endian byte accesses and returning a single done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  mem_ctrl_if.slave   bus
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;

  logic              ifDone_q, ifDone_d;
  logic [31:0]       ifData_q, ifData_d;
  logic              memEn_q, memEn_d;
  logic [31:0]       loadData_q, loadData_d;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic [7:0]        ramDout_q, ramDout_d;
  logic              ramWr_q, ramWr_d;

  logic              memReq;
  logic [2:0]        cntInc;
  logic [2:0]        capIdx;

  assign memReq = bus.load_or_not | bus.store_or_not;
  assign cntInc = cnt_q + 3'd1;
  assign capIdx = cnt_q - 3'(RAM_RD_LAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy) begin
          if (bus.store_or_not)                    state_d = ST_WRITE;
          else if (bus.load_or_not || bus.if_req)  state_d = ST_READ;
        end
      end
      ST_WRITE: if (cntInc >= size_q) state_d = ST_DONE;
      ST_READ:  if (cnt_q == size_q)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded one cycle ahead, so each branch computes what
  // the RAM port and done flags must show during the following cycle.
  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    ifDone_d   = 1'b0;
    ifData_d   = ifData_q;
    memEn_d    = 1'b0;
    loadData_d = loadData_q;
    ramAddr_d  = ramAddr_q;
    ramDout_d  = 8'h00;
    ramWr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rdy && (memReq || bus.if_req)) begin
          owner_d   = memReq ? OWN_MEM : OWN_IF;
          addr_d    = memReq ? bus.mem_addr : bus.if_addr;
          size_d    = memReq ? normSize(bus.num_of_bytes) : SZ_W;
          wdata_d   = bus.store_data;
          cnt_d     = 3'd0;
          asm_d     = 32'h0;
          ramAddr_d = addr_d;
          if (bus.store_or_not) begin
            ramWr_d   = 1'b1;
            ramDout_d = bus.store_data[7:0];
          end
        end
      end

      ST_WRITE: begin
        if (cntInc < size_q) begin
          cnt_d     = cntInc;
          ramAddr_d = addr_q + ADDR_W'(cntInc);
          ramDout_d = 8'(wdata_q >> {cntInc, 3'b000});
          ramWr_d   = 1'b1;
        end else begin
          ifDone_d = (owner_q == OWN_IF);
          memEn_d  = (owner_q == OWN_MEM);
        end
      end

      ST_READ: begin
        if (cnt_q >= 3'(RAM_RD_LAT))
          asm_d = asm_q | (32'(bus.ram_din) << {capIdx, 3'b000});
        if (cntInc < size_q)
          ramAddr_d = addr_q + ADDR_W'(cntInc);
        if (cnt_q == size_q) begin
          if (owner_q == OWN_IF) begin
            ifDone_d = 1'b1;
            ifData_d = asm_d;
          end else begin
            memEn_d    = 1'b1;
            loadData_d = asm_d;
          end
        end else begin
          cnt_d = cntInc;
        end
      end

      ST_DONE: begin
        owner_d = OWN_NONE;
        cnt_d   = 3'd0;
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_NONE;
      cnt_q      <= 3'd0;
      size_q     <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      asm_q      <= 32'h0;
      ifDone_q   <= 1'b0;
      ifData_q   <= 32'h0;
      memEn_q    <= 1'b0;
      loadData_q <= 32'h0;
      ramAddr_q  <= '0;
      ramDout_q  <= 8'h00;
      ramWr_q    <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      ifDone_q   <= ifDone_d;
      ifData_q   <= ifData_d;
      memEn_q    <= memEn_d;
      loadData_q <= loadData_d;
      ramAddr_q  <= ramAddr_d;
      ramDout_q  <= ramDout_d;
      ramWr_q    <= ramWr_d;
    end
  end

  assign bus.if_done    = ifDone_q;
  assign bus.if_data    = ifData_q;
  assign bus.mem_enable = memEn_q;
  assign bus.load_data  = loadData_q;
  assign bus.ram_addr   = ramAddr_q;
  assign bus.ram_dout   = ramDout_q;
  assign bus.ram_wr     = ramWr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a 1 KiB byte RAM model with one-cycle read
// latency, hand-computed expectations and immediate assertions.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  logic [7:0]  ram [0:1023];
  logic [39:0] wrQ [$];
  int nAsserts = 0;
  int nFail    = 0;

  // RAM model: write on the strobe, read data appears one cycle after the address.
  always @(posedge clk) begin
    if (bus.ram_wr) begin
      ram[bus.ram_addr[9:0]] = bus.ram_dout;
      wrQ.push_back({bus.ram_addr, bus.ram_dout});
    end
    bus.ram_din <= ram[bus.ram_addr[9:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic ld, input logic st, input logic [2:0] nb,
                               input logic [31:0] mAddr, input logic [31:0] sData);
    bus.if_req       = ifReq;
    bus.if_addr      = ifAddr;
    bus.load_or_not  = ld;
    bus.store_or_not = st;
    bus.num_of_bytes = nb;
    bus.mem_addr     = mAddr;
    bus.store_data   = sData;
  endtask

  // Returns the number of ticks until the selected done pulse, or -1 on timeout.
  task automatic waitDone(input bit forIf, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (forIf ? bus.if_done : bus.mem_enable) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int memAt;
    int ifAt;
    bit sawEn;

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h104] = 8'hA1; ram[10'h105] = 8'hB2; ram[10'h106] = 8'hC3; ram[10'h107] = 8'hD4;
    ram[10'h007] = 8'h80;
    ram[10'h010] = 8'h01; ram[10'h011] = 8'h02; ram[10'h012] = 8'h03; ram[10'h013] = 8'h04;
    ram[10'h020] = 8'h5E; ram[10'h021] = 8'h6F; ram[10'h022] = 8'h70; ram[10'h023] = 8'h81;
    ram[10'h202] = 8'h5A;
    ram[10'h3FE] = 8'h9A; ram[10'h3FF] = 8'hBC; ram[10'h000] = 8'hDE; ram[10'h001] = 8'hF0;

    rst = 1'b0;
    rdy = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    tick();

    checkOutput("reset_if_done",  64'(bus.if_done),    64'h0);
    checkOutput("reset_if_data",  64'(bus.if_data),    64'h0);
    checkOutput("reset_mem_en",   64'(bus.mem_enable), 64'h0);
    checkOutput("reset_ld_data",  64'(bus.load_data),  64'h0);
    checkOutput("reset_ram_addr", 64'(bus.ram_addr),   64'h0);
    checkOutput("reset_ram_dout", 64'(bus.ram_dout),   64'h0);
    checkOutput("reset_ram_wr",   64'(bus.ram_wr),     64'h0);
    checkOutput("reset_state",    64'(dut.state_q),    64'(ST_IDLE));

    rst = 1'b1;
    tick();

    $display("[TB] word fetch from 0x100");
    wrQ.delete();
    rdy = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    waitDone(1'b1, 20, lat);
    checkOutput("fetch_latency", 64'(lat), 64'd6);
    checkOutput("fetch_data", 64'(bus.if_data), 64'h44332211);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch_pulse_width", 64'(bus.if_done), 64'h0);
    checkOutput("fetch_data_held", 64'(bus.if_data), 64'h44332211);
    checkOutput("fetch_no_writes", 64'(wrQ.size()), 64'd0);

    $display("[TB] halfword store to 0x200");
    wrQ.delete();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 3'd2, 32'h200, 32'hAABBCCDD);
    waitDone(1'b0, 20, lat);
    checkOutput("sh_latency", 64'(lat), 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("sh_write_count", 64'(wrQ.size()), 64'd2);
    if (wrQ.size() == 2) begin
      checkOutput("sh_write0", 64'(wrQ[0]), 64'({32'h200, 8'hDD}));
      checkOutput("sh_write1", 64'(wrQ[1]), 64'({32'h201, 8'hCC}));
    end
    checkOutput("sh_ram_202_kept", 64'(ram[10'h202]), 64'h5A);
    checkOutput("sh_ram_wr_idle", 64'(bus.ram_wr), 64'h0);
    checkOutput("sh_ram_dout_idle", 64'(bus.ram_dout), 64'h0);

    $display("[TB] byte load from 0x7");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 3'd1, 32'h7, 32'h0);
    waitDone(1'b0, 20, lat);
    checkOutput("lb_latency", 64'(lat), 64'd3);
    checkOutput("lb_data", 64'(bus.load_data), 64'h00000080);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();

    $display("[TB] illegal size 3 load from 0x10 behaves as a word");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 3'd3, 32'h10, 32'h0);
    waitDone(1'b0, 20, lat);
    checkOutput("size3_latency", 64'(lat), 64'd6);
    checkOutput("size3_data", 64'(bus.load_data), 64'h04030201);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();

    $display("[TB] simultaneous fetch 0x104 and word load 0x20");
    memAt = -1;
    ifAt  = -1;
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 3'd4, 32'h20, 32'h0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.mem_enable && memAt < 0) begin
        memAt = i;
        checkOutput("arb_load_data", 64'(bus.load_data), 64'h81706F5E);
        bus.load_or_not = 1'b0;
      end
      if (bus.if_done && ifAt < 0) begin
        ifAt = i;
        checkOutput("arb_if_data", 64'(bus.if_data), 64'hD4C3B2A1);
        bus.if_req = 1'b0;
        break;
      end
    end
    checkOutput("arb_mem_first_at", 64'(memAt), 64'd6);
    checkOutput("arb_if_second_at", 64'(ifAt), 64'd13);
    tick();

    $display("[TB] fetch held off by rdy=0, wrapping address 0xFFFFFFFE");
    wrQ.delete();
    rdy = 1'b0;
    applyStimulus(1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("rdy0_state", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("rdy0_ram_addr_held", 64'(bus.ram_addr), 64'h107);
    rdy = 1'b1;
    waitDone(1'b1, 20, lat);
    checkOutput("rdy1_fetch_latency", 64'(lat), 64'd6);
    checkOutput("wrap_fetch_data", 64'(bus.if_data), 64'hF0DEBC9A);
    checkOutput("wrap_ram_addr", 64'(bus.ram_addr), 64'h00000001);
    checkOutput("wrap_no_writes", 64'(wrQ.size()), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();

    $display("[TB] word store to 0x300 with rdy dropped mid-write");
    wrQ.delete();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 3'd4, 32'h300, 32'h11223344);
    tick();
    rdy = 1'b0;
    waitDone(1'b0, 20, lat);
    checkOutput("sw_rdy0_latency", 64'(lat), 64'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("sw_write_count", 64'(wrQ.size()), 64'd4);
    checkOutput("sw_ram_word", 64'({ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}),
                64'h11223344);
    rdy = 1'b1;

    $display("[TB] reset during second byte of a word store to 0x320");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 3'd4, 32'h320, 32'hCAFEBABE);
    tick();
    tick();
    checkOutput("rst_pre_ram_wr", 64'(bus.ram_wr), 64'h1);
    checkOutput("rst_pre_ram_addr", 64'(bus.ram_addr), 64'h321);
    rst = 1'b0;
    #1;
    checkOutput("rst_async_ram_wr", 64'(bus.ram_wr), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    sawEn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.mem_enable) sawEn = 1'b1;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_enable) sawEn = 1'b1;
    end
    checkOutput("rst_no_mem_enable", 64'(sawEn), 64'h0);
    checkOutput("rst_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("rst_cnt_zero", 64'(dut.cnt_q), 64'h0);
    checkOutput("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
    checkOutput("rst_if_data", 64'(bus.if_data), 64'h0);
    checkOutput("rst_load_data", 64'(bus.load_data), 64'h0);
    checkOutput("rst_partial_byte0", 64'(ram[10'h320]), 64'hBE);
    checkOutput("rst_byte1_unwritten", 64'(ram[10'h321]), 64'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
